// File: rtl/reg_dump_reader_if.sv
// Bundle of the scanner's control, register-file read port and output stream.
interface reg_dump_reader_if #(
  parameter int unsigned PW = 4,
  parameter int unsigned DW = 8
) ();

  logic          start;
  logic          abort;
  logic [PW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  // Scanner side: drives the read address and the output stream.
  modport master (
    input  start, abort, rd_data, out_ready,
    output rd_addr, out_data, out_addr, out_valid, busy, done
  );

  // Environment side: register file, controller and downstream consumer.
  modport slave (
    output start, abort, rd_data, out_ready,
    input  rd_addr, out_data, out_addr, out_valid, busy, done
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks every register-file entry in address order and emits each word,
// tagged with its address, on a valid/ready stream. Read-only to the file.
module reg_dump_reader #(
  parameter int unsigned PW = 4,
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_dump_reader_if.master bus
);

  // All-ones address marks the final entry, so the counter never wraps.
  localparam logic [PW-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q,     state_d;
  logic [PW-1:0] rd_addr_q,   rd_addr_d;
  logic [DW-1:0] out_data_q,  out_data_d;
  logic [PW-1:0] out_addr_q,  out_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rd_addr_d = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        // Combinational read port: rd_data belongs to rd_addr this cycle.
        out_data_d  = bus.rd_data;
        out_addr_d  = rd_addr_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (rd_addr_q == ADDR_LAST) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + PW'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      rd_addr_d   = '0;
    end

    // Status flags are registered copies of what the next state implies.
    busy_d = (state_d == S_FETCH) || (state_d == S_SEND);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
